vram_scheduler: RTL and testbench
=================================

VRAM_SCHEDULER -- requirements
Module: vram_scheduler

Interface
REQ-001 Parameter size, default 16, SHALL be the glyph size in pixels (power of 2, 8..256).
REQ-002 Parameter DEPTH, default 4, SHALL be the write-FIFO depth (power of 2, 2..16).
REQ-003 Derived CELLS SHALL equal (640/size)*(480/size); for size=16, CELLS=1200.
REQ-004 Clock and reset: the block has one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all logic on its rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 wr_req  in  1  console write request, one push per high cycle.
REQ-008 wr_addr  in  13  console target cell address.
REQ-009 wr_data  in  8  console character.
REQ-010 wr_full  out  1  write FIFO full.
REQ-011 wr_ovf  out  1  sticky: a push was dropped.
REQ-012 rd_req  in  1  renderer read request.
REQ-013 rd_addr  in  13  renderer cell address.
REQ-014 rd_data  out  8  renderer read data.
REQ-015 rd_valid  out  1  rd_data valid.
REQ-016 clr_start  in  1  start-screen-clear pulse.
REQ-017 clr_busy  out  1  clear in progress.
REQ-018 ram_addr  out  13  single-port VRAM address.
REQ-019 ram_we  out  1  VRAM write enable.
REQ-020 ram_wdata  out  8  VRAM write data.
REQ-021 ram_rdata  in  8  VRAM read data, valid one cycle after the address.

Function
REQ-022 The FIFO SHALL accept a push when wr_req=1 and count<DEPTH; a pop in the same cycle SHALL NOT free space for that push.
REQ-023 A push with count==DEPTH SHALL be dropped and SHALL set wr_ovf until reset.
REQ-024 wr_full SHALL equal (count==DEPTH) from registered state.
REQ-025 Per-cycle port grant priority SHALL be: rd_req, then clear engine, then FIFO pop.
REQ-026 A granted read SHALL drive ram_addr=rd_addr and ram_we=0; rd_valid SHALL be 1 and rd_data SHALL equal ram_rdata exactly 2 cycles after the rd_req cycle (address register plus RAM latency).
REQ-027 A granted FIFO pop SHALL drive the oldest entry's address and data with ram_we=1 for one cycle.
REQ-028 FIFO entries with address >= CELLS SHALL be popped and discarded with ram_we=0.
REQ-029 The FSM SHALL have states IDLE and CLEAR.
REQ-030 IDLE->CLEAR on clr_start=1; clear pointer loads 0; clr_busy=1 from the next cycle.
REQ-031 In CLEAR, each cycle without rd_req SHALL write 8'h00 to the pointer address, then increment the pointer; rd_req stalls the pointer.
REQ-032 CLEAR->IDLE after the write to CELLS-1; clr_busy SHALL fall the following cycle.
REQ-033 clr_start during CLEAR SHALL be ignored and SHALL NOT restart the pointer.
REQ-034 FIFO pushes SHALL continue during CLEAR; pops SHALL be held until IDLE, so console writes land after the clear.
REQ-035 ram_addr, ram_we and ram_wdata SHALL be registered, one cycle after the grant decision.

Reset
REQ-036 With rstn=0: FIFO empty, wr_full=0, wr_ovf=0, rd_valid=0, rd_data=0, ram_we=0, ram_addr=0, ram_wdata=0, clr_busy=0, FSM=IDLE.
REQ-037 Reset asserted mid-clear SHALL abort the clear immediately with no further writes, and SHALL discard FIFO contents.

Configuration
REQ-038 Macro VRAM_SCHED_CLEAR_EN: when defined, the CLEAR state and clear engine SHALL exist as specified.
REQ-039 Without VRAM_SCHED_CLEAR_EN, clr_start SHALL be ignored, clr_busy SHALL be 0, the FSM SHALL remain in IDLE, and arbitration SHALL be read over FIFO pop.

Verification
REQ-040 Push (addr 5, 'A') with no reads -> ram_we=1, ram_addr=5, ram_wdata=8'h41 within 2 cycles.
REQ-041 rd_req held high for 10 cycles with 4 pushes queued -> no ram_we during those cycles; 4 writes in order immediately after; rd_valid on every data cycle.
REQ-042 5 pushes in consecutive cycles with reads blocking pops, DEPTH=4 -> wr_full=1 after the 4th push, 5th push dropped, wr_ovf=1.
REQ-043 clr_start with size=16 and no reads -> exactly 1200 writes of 8'h00 to addresses 0..1199; clr_busy high for 1200 cycles; a push queued mid-clear is written after the last clear write.
REQ-044 rstn low at clear address 600 -> no further ram_we, clr_busy=0, FSM IDLE after release.
REQ-045 Push to address 1300 (size=16) -> entry popped with no ram_we.

Source files
------------

// File: rtl/vram_scheduler.sv
// vram_scheduler: shares one single-port VRAM between renderer reads, a screen-clear engine (`VRAM_SCHED_CLEAR_EN) and a console write FIFO.
// Latency: RAM bus registered one cycle after grant; rd_valid/rd_data two cycles after rd_req.
// Backpressure: reads never stall; console pushes into a full FIFO are dropped (wr_full, sticky wr_ovf).

module vram_sched_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full is judged on registered count, so a same-cycle pop never makes room.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rp];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_dat;
  end
endmodule

module vram_scheduler #(
  parameter int size  = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_req,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_full,
  output logic        wr_ovf,
  input  logic        rd_req,
  input  logic [12:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);
  localparam int          CELLS   = (640 / size) * (480 / size);
  localparam logic [12:0] CELLS13 = 13'(CELLS);
  localparam logic [12:0] LAST    = 13'(CELLS - 1);

  logic [20:0] head;
  logic [12:0] head_addr;
  logic [7:0]  head_data;
  logic        fifo_empty;
  logic        clearing;
  logic [12:0] clr_ptr;
  logic        g_rd;
  logic        g_clr;
  logic        g_pop;
  logic [1:0]  rd_pipe;

  assign head_addr = head[20:8];
  assign head_data = head[7:0];

  vram_sched_fifo #(.W(21), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (wr_req),
    .push_dat ({wr_addr, wr_data}),
    .pop      (g_pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (wr_full)
  );

`ifdef VRAM_SCHED_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t      state;
  state_t      state_nxt;
  logic [12:0] ptr_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  end

  // A read in CLEAR steals the port, so the pointer only moves on cycles the clear owns it.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (!rd_req) begin
          ptr_nxt = clr_ptr + 13'd1;
          if (clr_ptr == LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clearing = (state == CLEAR);
`else
  logic unused_clr;
  assign unused_clr = clr_start;
  assign clearing   = 1'b0;
  assign clr_ptr    = '0;
`endif

  assign clr_busy = clearing;

  // Pops are held for the whole clear so queued console text lands on the cleared screen.
  always_comb begin
    g_rd  = rd_req;
    g_clr = !rd_req && clearing;
    g_pop = !rd_req && !clearing && !fifo_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      rd_pipe   <= '0;
      wr_ovf    <= 1'b0;
    end else begin
      ram_we  <= 1'b0;
      if (g_rd) begin
        ram_addr <= rd_addr;
      end else if (g_clr) begin
        ram_addr  <= clr_ptr;
        ram_wdata <= 8'h00;
        ram_we    <= 1'b1;
      end else if (g_pop) begin
        ram_addr  <= head_addr;
        ram_wdata <= head_data;
        ram_we    <= (head_addr < CELLS13);
      end
      rd_pipe <= {rd_pipe[0], g_rd};
      if (wr_req && wr_full) wr_ovf <= 1'b1;
    end
  end

  assign rd_valid = rd_pipe[1];
  assign rd_data  = rd_pipe[1] ? ram_rdata : 8'h00;
endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: directed scenarios plus a randomized run checked against a queue-based
// model of the port arbitration, write FIFO, clear engine and a synchronous VRAM.
module tb_vram_scheduler;
  localparam int SIZE  = 16;
  localparam int DEPTH = 4;
  localparam int CELLS = (640 / SIZE) * (480 / SIZE);

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_full;
  logic        wr_ovf;
  logic        rd_req;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        clr_start;
  logic        clr_busy;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int errors = 0;

  vram_scheduler #(.size(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full), .wr_ovf(wr_ovf),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port VRAM: read data appears the cycle after the address.
  logic [7:0] vmem [8192];
  always @(posedge clk) begin
    if (ram_we) vmem[ram_addr] <= ram_wdata;
    ram_rdata <= vmem[ram_addr];
  end

  // Reference model: one arbitration decision per clock, expectations for the following cycle.
  typedef struct { int due; logic [7:0] dat; } rdexp_t;
  logic [20:0] mq[$];
  rdexp_t      rq[$];
  logic [7:0]  mm [8192];
  logic [20:0] m_e;
  bit          m_clr, m_ovf, busy0, pend_we;
  int          m_ptr, n0;
  int          cyc = 0;
  logic [12:0] pend_addr;
  logic [7:0]  pend_dat;
  bit          exp_we, exp_rd, exp_rdv, exp_full, exp_busy;
  logic [12:0] exp_addr;
  logic [7:0]  exp_wdata, exp_rdata;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete(); rq.delete();
      m_clr = 0; m_ovf = 0; m_ptr = 0; pend_we = 0;
      exp_we = 0; exp_rd = 0; exp_rdv = 0; exp_full = 0; exp_busy = 0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      cyc++;
    end else begin
      if (pend_we) mm[pend_addr] = pend_dat;
      pend_we = 0; exp_we = 0; exp_rd = 0;
      n0 = mq.size(); busy0 = m_clr;
      if (rd_req) begin
        exp_rd = 1; exp_addr = rd_addr;
        rq.push_back('{due: cyc + 2, dat: mm[rd_addr]});
      end else if (m_clr) begin
        exp_we = 1; exp_addr = 13'(m_ptr); exp_wdata = 8'h00;
        m_ptr++;
        if (m_ptr == CELLS) m_clr = 0;
      end else if (n0 > 0) begin
        m_e = mq.pop_front();
        if (int'(m_e[20:8]) < CELLS) begin
          exp_we = 1; exp_addr = m_e[20:8]; exp_wdata = m_e[7:0];
        end
      end
      if (wr_req) begin
        if (n0 < DEPTH) mq.push_back({wr_addr, wr_data});
        else m_ovf = 1;
      end
`ifdef VRAM_SCHED_CLEAR_EN
      if (clr_start && !busy0) begin m_clr = 1; m_ptr = 0; end
`endif
      if (exp_we) begin pend_we = 1; pend_addr = exp_addr; pend_dat = exp_wdata; end
      cyc++;
      exp_rdv = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rdv = 1; exp_rdata = rq[0].dat; void'(rq.pop_front());
      end
      exp_full = (mq.size() == DEPTH);
      exp_busy = m_clr;
    end
  end

  task automatic idle_inputs();
    wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0; clr_start = 0;
  endtask

  task automatic test_reset();
    rstn = 0; rd_req = 1; rd_addr = 13'd77; wr_req = 1; wr_addr = 13'd3; wr_data = 8'h12; clr_start = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_full, wr_ovf, rd_valid, clr_busy, ram_we} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, expected 00000", {wr_full, wr_ovf, rd_valid, clr_busy, ram_we});
    end
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h, expected 00", rd_data); end
    checks++;
    if (ram_addr !== 13'h0 || ram_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_ram_bus: got addr %0d data %h, expected 0 00", ram_addr, ram_wdata);
    end
    idle_inputs();
    @(negedge clk); rstn = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_push();
    bit found = 0;
    wr_req = 1; wr_addr = 13'd5; wr_data = 8'h41;
    @(negedge clk); wr_req = 0;
    for (int i = 0; i < 2 && !found; i++) begin
      if (ram_we === 1'b1) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL push_we: no ram_we within 2 cycles, expected 1"); end
    checks++;
    if (ram_addr !== 13'd5 || ram_wdata !== 8'h41) begin
      errors++; $display("FAIL push_bus: got addr %0d data %h, expected 5 41", ram_addr, ram_wdata);
    end
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL push_once: ram_we %b, expected 0", ram_we); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_block();
    logic [12:0] pa [4];
    logic [7:0]  pd [4];
    int we_seen = 0, rdv_bad = 0, order_bad = 0;
    for (int c = 0; c < 10; c++) begin
      rd_req = 1; rd_addr = 13'($urandom_range(0, CELLS - 1));
      wr_req = (c < 4);
      if (c < 4) begin
        pa[c] = 13'($urandom_range(0, CELLS - 1)); pd[c] = 8'($urandom);
        wr_addr = pa[c]; wr_data = pd[c];
      end
      @(negedge clk);
      if (ram_we !== 1'b0) we_seen++;
      if (c >= 1 && (rd_valid !== 1'b1 || rd_data !== exp_rdata)) rdv_bad++;
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0 && (rd_valid !== 1'b1 || rd_data !== exp_rdata)) rdv_bad++;
      if (ram_we !== 1'b1 || ram_addr !== pa[k] || ram_wdata !== pd[k]) order_bad++;
    end
    checks++;
    if (we_seen != 0) begin errors++; $display("FAIL rdblock_no_we: %0d write cycles, expected 0", we_seen); end
    checks++;
    if (rdv_bad != 0) begin errors++; $display("FAIL rdblock_rd_valid: %0d bad data cycles, expected 0", rdv_bad); end
    checks++;
    if (order_bad != 0) begin errors++; $display("FAIL rdblock_drain: %0d bad writes, expected 0", order_bad); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [12:0] pa [5];
    logic [7:0]  pd [5];
    int nwr = 0, bad = 0;
    for (int c = 0; c < 8; c++) begin
      rd_req = 1; rd_addr = 13'($urandom_range(0, CELLS - 1));
      wr_req = (c < 5);
      if (c < 5) begin
        pa[c] = 13'($urandom_range(0, CELLS - 1)); pd[c] = 8'($urandom);
        wr_addr = pa[c]; wr_data = pd[c];
      end
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (wr_full !== 1'b0) begin errors++; $display("FAIL ovf_full_3: got %b, expected 0", wr_full); end
      end
      if (c == 3) begin
        checks++;
        if (wr_full !== 1'b1 || wr_ovf !== 1'b0) begin
          errors++; $display("FAIL ovf_full_4: got full %b ovf %b, expected 1 0", wr_full, wr_ovf);
        end
      end
      if (c == 4) begin
        checks++;
        if (wr_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky_5: got %b, expected 1", wr_ovf); end
      end
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        if (nwr < 4 && (ram_addr !== pa[nwr] || ram_wdata !== pd[nwr])) bad++;
        nwr++;
      end
    end
    checks++;
    if (nwr != 4 || bad != 0) begin errors++; $display("FAIL ovf_drain: %0d writes %0d wrong, expected 4 0", nwr, bad); end
    checks++;
    if (wr_ovf !== 1'b1 || wr_full !== 1'b0) begin
      errors++; $display("FAIL ovf_after_drain: got ovf %b full %b, expected 1 0", wr_ovf, wr_full);
    end
    rstn = 0; @(negedge clk); rstn = 1;
    checks++;
    if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b, expected 0", wr_ovf); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bad_addr();
    int nwr = 0, wv = 0;
    logic [12:0] wa = '0;
    logic [7:0]  wd = '0;
    wr_req = 1; wr_addr = 13'(CELLS + 100); wr_data = 8'h55;
    for (int v = 1; v <= 5; v++) begin
      @(negedge clk);
      if (v == 1) begin wr_addr = 13'd9; wr_data = 8'h77; end
      else wr_req = 0;
      if (ram_we === 1'b1) begin nwr++; wa = ram_addr; wd = ram_wdata; wv = v; end
    end
    checks++;
    if (nwr != 1) begin errors++; $display("FAIL bad_addr_writes: got %0d, expected 1", nwr); end
    checks++;
    if (wa !== 13'd9 || wd !== 8'h77 || wv != 3) begin
      errors++; $display("FAIL bad_addr_next: got addr %0d data %h cycle %0d, expected 9 77 3", wa, wd, wv);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef VRAM_SCHED_CLEAR_EN
  task automatic test_clear();
    int busy_cnt = 0, first_busy = -1, idx = 0, seq_bad = 0;
    logic [12:0] post_addr = '0;
    logic [7:0]  post_dat = '0;
    clr_start = 1;
    for (int v = 1; v <= CELLS + 10; v++) begin
      @(negedge clk);
      clr_start = (v == 300);
      wr_req = (v == 600); wr_addr = 13'd7; wr_data = 8'h5A;
      if (clr_busy === 1'b1) begin busy_cnt++; if (first_busy < 0) first_busy = v; end
      if (ram_we === 1'b1) begin
        if (idx < CELLS) begin
          if (ram_addr !== 13'(idx) || ram_wdata !== 8'h00) seq_bad++;
        end else if (idx == CELLS) begin
          post_addr = ram_addr; post_dat = ram_wdata;
        end
        idx++;
      end
    end
    idle_inputs();
    checks++;
    if (busy_cnt != CELLS || first_busy != 1) begin
      errors++; $display("FAIL clear_busy: %0d cycles from %0d, expected %0d from 1", busy_cnt, first_busy, CELLS);
    end
    checks++;
    if (seq_bad != 0) begin errors++; $display("FAIL clear_seq: %0d wrong writes, expected 0", seq_bad); end
    checks++;
    if (idx != CELLS + 1) begin errors++; $display("FAIL clear_count: %0d writes, expected %0d", idx, CELLS + 1); end
    checks++;
    if (post_addr !== 13'd7 || post_dat !== 8'h5A) begin
      errors++; $display("FAIL clear_post_push: got addr %0d data %h, expected 7 5a", post_addr, post_dat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear_reset();
    bit found = 0;
    int nwe = 0, nbusy = 0;
    clr_start = 1;
    for (int v = 1; v <= CELLS + 10 && !found; v++) begin
      @(negedge clk);
      clr_start = 0;
      wr_req = (v == 100); wr_addr = 13'd3; wr_data = 8'h99;
      if (ram_we === 1'b1 && ram_addr === 13'd600) found = 1;
    end
    idle_inputs();
    checks++;
    if (!found) begin errors++; $display("FAIL clr_rst_reach: write to 600 not seen, expected seen"); end
    rstn = 0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || clr_busy !== 1'b0) begin
      errors++; $display("FAIL clr_rst_abort: got we %b busy %b, expected 0 0", ram_we, clr_busy);
    end
    @(negedge clk); rstn = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ram_we !== 1'b0) nwe++;
      if (clr_busy !== 1'b0) nbusy++;
    end
    checks++;
    if (nwe != 0 || nbusy != 0) begin
      errors++; $display("FAIL clr_rst_after: %0d writes %0d busy cycles, expected 0 0", nwe, nbusy);
    end
  endtask
`else
  task automatic test_clear_disabled();
    int nwe = 0, nbusy = 0;
    clr_start = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      clr_start = (k == 10);
      if (ram_we !== 1'b0) nwe++;
      if (clr_busy !== 1'b0) nbusy++;
    end
    idle_inputs();
    checks++;
    if (nwe != 0 || nbusy != 0) begin
      errors++; $display("FAIL clear_disabled: %0d writes %0d busy cycles, expected 0 0", nwe, nbusy);
    end
  endtask
`endif

  task automatic test_random();
    int rdpct;
    for (int c = 0; c < 4000; c++) begin
      rdpct = (c < 2000) ? 20 : 70;
      rd_req = ($urandom_range(0, 99) < rdpct);
      rd_addr = 13'($urandom_range(0, CELLS - 1));
      wr_req = ($urandom_range(0, 99) < 50);
      wr_addr = ($urandom_range(0, 9) == 0) ? 13'(CELLS + $urandom_range(0, 100))
                                            : 13'($urandom_range(0, CELLS - 1));
      wr_data = 8'($urandom);
      clr_start = ($urandom_range(0, 999) == 0);
      @(negedge clk);
      checks++;
      if (ram_we !== exp_we) begin errors++; $display("FAIL rnd_we c=%0d: got %b, expected %b", c, ram_we, exp_we); end
      if (exp_we) begin
        checks++;
        if (ram_addr !== exp_addr || ram_wdata !== exp_wdata) begin
          errors++; $display("FAIL rnd_write c=%0d: got %0d/%h, expected %0d/%h", c, ram_addr, ram_wdata, exp_addr, exp_wdata);
        end
      end
      if (exp_rd) begin
        checks++;
        if (ram_addr !== exp_addr) begin errors++; $display("FAIL rnd_rd_addr c=%0d: got %0d, expected %0d", c, ram_addr, exp_addr); end
      end
      checks++;
      if (rd_valid !== exp_rdv) begin errors++; $display("FAIL rnd_rd_valid c=%0d: got %b, expected %b", c, rd_valid, exp_rdv); end
      if (exp_rdv) begin
        checks++;
        if (rd_data !== exp_rdata) begin errors++; $display("FAIL rnd_rd_data c=%0d: got %h, expected %h", c, rd_data, exp_rdata); end
      end
      checks++;
      if ({wr_full, wr_ovf, clr_busy} !== {exp_full, m_ovf, exp_busy}) begin
        errors++; $display("FAIL rnd_flags c=%0d: full/ovf/busy got %b, expected %b", c, {wr_full, wr_ovf, clr_busy}, {exp_full, m_ovf, exp_busy});
      end
    end
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    rstn = 0;
    idle_inputs();
    for (int i = 0; i < 8192; i++) begin
      b = 8'($urandom);
      vmem[i] <= b;
      mm[i] = b;
    end
    test_reset();
    test_single_push();
    test_read_block();
    test_overflow();
    test_bad_addr();
`ifdef VRAM_SCHED_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
